// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage.
//   - RV32/RV64 major opcodes
//   - widths and bit positions of the one-hot info vectors (MSB first)
//   - immediate-format enum, decoded-instruction struct, illegal default
//   - small ALU-op lookup helpers shared by the I- and R-type decoders
package decode_pkg;

  localparam int OPC_W = 12;
  localparam int ALU_W = 28;
  localparam int BR_W  = 6;
  localparam int LS_W  = 11;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  // opcode_info bit positions
  localparam int OI_LUI = 11, OI_AUIPC = 10, OI_JAL = 9, OI_JALR = 8;
  localparam int OI_BRANCH = 7, OI_LOAD = 6, OI_STORE = 5, OI_ALU_IMM = 4;
  localparam int OI_ALU_IMMW = 3, OI_ALU_REG = 2, OI_ALU_REGW = 1, OI_SYSTEM = 0;

  // alu_info bit positions
  localparam int AI_ADD = 27, AI_SUB = 26, AI_SLL = 25, AI_SLT = 24, AI_SLTU = 23;
  localparam int AI_XOR = 22, AI_SRL = 21, AI_SRA = 20, AI_OR = 19, AI_AND = 18;
  localparam int AI_ADDW = 17, AI_SUBW = 16, AI_SLLW = 15, AI_SRLW = 14, AI_SRAW = 13;
  localparam int AI_MUL = 12;   // mul..remu occupy 12 downto 5 in funct3 order
  localparam int AI_MULW = 4;
  localparam int AI_DIVW = 3;   // divw..remuw occupy 3 downto 0

  // All word-sized (W) ALU ops
  localparam logic [ALU_W-1:0] ALU_W_MASK = 28'h003E01F;

  // branch_info / ls_info bit positions
  localparam int BI_BEQ = 5, BI_BLT = 3;
  localparam int LI_LB = 10, LI_SB = 3;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_e;

  typedef struct packed {
    logic [OPC_W-1:0] opc;
    logic [ALU_W-1:0] alu;
    logic [BR_W-1:0]  br;
    logic [LS_W-1:0]  ls;
    imm_e             imm;
    logic             writes_rd;
    logic             illegal;
  } dec_t;

  localparam dec_t DEC_ILLEGAL = '{opc: '0, alu: '0, br: '0, ls: '0, imm: IMM_NONE,
                                   writes_rd: 1'b0, illegal: 1'b1};

  // Base-ISA ALU op from funct3; arith selects sub/sra
  function automatic int alu_base(input logic [2:0] f3, input logic arith);
    int idx;
    case (f3)
      3'b000:  idx = arith ? AI_SUB : AI_ADD;
      3'b001:  idx = AI_SLL;
      3'b010:  idx = AI_SLT;
      3'b011:  idx = AI_SLTU;
      3'b100:  idx = AI_XOR;
      3'b101:  idx = arith ? AI_SRA : AI_SRL;
      3'b110:  idx = AI_OR;
      default: idx = AI_AND;
    endcase
    return idx;
  endfunction

  // Word ALU op from funct3; unsupported funct3 values are rejected by the caller
  function automatic int alu_w_base(input logic [2:0] f3, input logic arith);
    int idx;
    case (f3)
      3'b001:  idx = AI_SLLW;
      3'b101:  idx = arith ? AI_SRAW : AI_SRLW;
      default: idx = arith ? AI_SUBW : AI_ADDW;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Integer register file for the decode stage.
//   clk_i, rst_i         clock, synchronous active-high reset (clears all registers)
//   we_i/wa_i/wd_i       write port (writes to x0 ignored)
//   ra1_i/ra2_i          read addresses
//   rd1_o/rd2_o          combinational read data; x0 reads 0, same-cycle write is forwarded
module decode_regfile #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [4:0]      wa_i,
  input  logic [XLEN-1:0] wd_i,
  input  logic [4:0]      ra1_i,
  input  logic [4:0]      ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o
);

  logic [XLEN-1:0] regs_q [32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = '0;
    rd2_o = '0;
    if (ra1_i != 5'd0) rd1_o = (we_i && (wa_i == ra1_i)) ? wd_i : regs_q[ra1_i];
    if (ra2_i != 5'd0) rd2_o = (we_i && (wa_i == ra2_i)) ? wd_i : regs_q[ra2_i];
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32/RV64 decode stage with RAW scoreboard.
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         fetch handshake; in_instr, in_pc
//   wb_wen/wb_rd/wb_wdata     write-back port (register file + scoreboard clear)
//   flush                     kills the held entry, blocks acceptance this cycle
//   out_valid/out_ready       execute handshake
//   out_pc, out_*_info        registered PC and one-hot decode vectors
//   out_rs1_data/rs2_data     operands, out_imm sign-extended immediate
//   out_rd, out_need_rd       destination and "writes a non-zero rd"
//   out_illegal               unsupported encoding (info vectors forced to 0)
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 64,
  parameter bit EN_M = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             wb_wen,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_wdata,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [OPC_W-1:0] out_opcode_info,
  output logic [ALU_W-1:0] out_alu_info,
  output logic [BR_W-1:0]  out_branch_info,
  output logic [LS_W-1:0]  out_ls_info,
  output logic [XLEN-1:0]  out_rs1_data,
  output logic [XLEN-1:0]  out_rs2_data,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_rd,
  output logic             out_need_rd,
  output logic             out_illegal
);

  localparam bit RV32 = (XLEN == 32);

  function automatic logic [XLEN-1:0] imm_of(input imm_e k, input logic [31:0] ins);
    logic [XLEN-1:0] r;
    case (k)
      IMM_I:   r = XLEN'($signed(ins[31:20]));
      IMM_S:   r = XLEN'($signed({ins[31:25], ins[11:7]}));
      IMM_B:   r = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      IMM_U:   r = XLEN'($signed({ins[31:12], 12'b0}));
      IMM_J:   r = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    d  = '0;
    ok = 1'b1;
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (ins[6:0])
      OPC_LUI:   begin d.opc[OI_LUI] = 1'b1; d.imm = IMM_U; d.writes_rd = 1'b1; end
      OPC_AUIPC: begin d.opc[OI_AUIPC] = 1'b1; d.imm = IMM_U; d.writes_rd = 1'b1; end
      OPC_JAL:   begin d.opc[OI_JAL] = 1'b1; d.imm = IMM_J; d.writes_rd = 1'b1; end
      OPC_JALR: begin
        d.opc[OI_JALR] = 1'b1; d.imm = IMM_I; d.writes_rd = 1'b1;
        ok = (f3 == 3'b000);
      end
      OPC_BRANCH: begin
        d.opc[OI_BRANCH] = 1'b1; d.imm = IMM_B;
        ok = (f3[2:1] != 2'b01);
        d.br[f3[2] ? (BI_BLT - int'(f3[1:0])) : (BI_BEQ - int'(f3[0]))] = 1'b1;
      end
      OPC_LOAD: begin
        d.opc[OI_LOAD] = 1'b1; d.imm = IMM_I; d.writes_rd = 1'b1;
        d.ls[LI_LB - int'(f3)] = 1'b1;
        // ld and lwu only exist on RV64
        ok = (f3 != 3'b111) && !(RV32 && ((f3 == 3'b011) || (f3 == 3'b110)));
      end
      OPC_STORE: begin
        d.opc[OI_STORE] = 1'b1; d.imm = IMM_S;
        d.ls[LI_SB - int'(f3[1:0])] = 1'b1;
        ok = !f3[2] && !(RV32 && (f3 == 3'b011));
      end
      OPC_OPIMM: begin
        d.opc[OI_ALU_IMM] = 1'b1; d.imm = IMM_I; d.writes_rd = 1'b1;
        d.alu[alu_base(f3, (f3 == 3'b101) && ins[30])] = 1'b1;
        // Shift amounts are 6 bits on RV64; shamt[5] must be 0 on RV32
        if (f3 == 3'b001)
          ok = (ins[31:26] == 6'b000000) && !(RV32 && ins[25]);
        else if (f3 == 3'b101)
          ok = ((ins[31:26] == 6'b000000) || (ins[31:26] == 6'b010000)) && !(RV32 && ins[25]);
      end
      OPC_OPIMM32: begin
        d.opc[OI_ALU_IMMW] = 1'b1; d.imm = IMM_I; d.writes_rd = 1'b1;
        d.alu[alu_w_base(f3, (f3 == 3'b101) && ins[30])] = 1'b1;
        ok = !RV32;
        case (f3)
          3'b000:  ;
          3'b001:  ok = ok && (f7 == 7'h00);
          3'b101:  ok = ok && ((f7 == 7'h00) || (f7 == 7'h20));
          default: ok = 1'b0;
        endcase
      end
      OPC_OP: begin
        d.opc[OI_ALU_REG] = 1'b1; d.writes_rd = 1'b1;
        case (f7)
          7'h00: d.alu[alu_base(f3, 1'b0)] = 1'b1;
          7'h20: begin
            d.alu[alu_base(f3, 1'b1)] = 1'b1;
            ok = (f3 == 3'b000) || (f3 == 3'b101);
          end
          7'h01: begin
            d.alu[AI_MUL - int'(f3)] = 1'b1;
            ok = EN_M;
          end
          default: ok = 1'b0;
        endcase
      end
      OPC_OP32: begin
        d.opc[OI_ALU_REGW] = 1'b1; d.writes_rd = 1'b1;
        ok = !RV32;
        case (f7)
          7'h00: begin
            d.alu[alu_w_base(f3, 1'b0)] = 1'b1;
            ok = ok && ((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101));
          end
          7'h20: begin
            d.alu[alu_w_base(f3, 1'b1)] = 1'b1;
            ok = ok && ((f3 == 3'b000) || (f3 == 3'b101));
          end
          7'h01: begin
            // mulw at funct3 0, divw..remuw at funct3 4..7
            d.alu[(f3 == 3'b000) ? AI_MULW : (AI_DIVW + 4 - int'(f3))] = 1'b1;
            ok = ok && EN_M && ((f3 == 3'b000) || f3[2]);
          end
          default: ok = 1'b0;
        endcase
      end
      OPC_SYSTEM: begin
        d.opc[OI_SYSTEM] = 1'b1; d.imm = IMM_I;
        d.writes_rd = (f3 != 3'b000);  // only CSR forms write rd
        ok = (f3 != 3'b100);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) d = DEC_ILLEGAL;
    if (RV32) d.alu = d.alu & ~ALU_W_MASK;
    return d;
  endfunction

  dec_t            dec;
  logic [4:0]      rs1, rs2, rd;
  logic            need_rs1, need_rs2, need_rd;
  logic            hz1, hz2, accept, issue;
  logic [XLEN-1:0] rs1_data, rs2_data;

  logic             vld_q, vld_d;
  logic [31:0]      sb_q, sb_d;
  logic [XLEN-1:0]  pc_q, rs1_q, rs2_q, imm_q;
  logic [OPC_W-1:0] opc_q;
  logic [ALU_W-1:0] alu_q;
  logic [BR_W-1:0]  br_q;
  logic [LS_W-1:0]  ls_q;
  logic [4:0]       rd_q;
  logic             need_rd_q, illegal_q;

  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign rd  = in_instr[11:7];
  assign dec = decode(in_instr);

  assign need_rs1 = !(dec.opc[OI_LUI] || dec.opc[OI_AUIPC] || dec.opc[OI_JAL]);
  assign need_rs2 = dec.opc[OI_ALU_REG] || dec.opc[OI_ALU_REGW] || dec.opc[OI_BRANCH]
                 || dec.opc[OI_STORE];
  assign need_rd  = dec.writes_rd && (rd != 5'd0);

  decode_regfile #(.XLEN(XLEN)) u_rf (
    .clk_i (clk),
    .rst_i (rst),
    .we_i  (wb_wen),
    .wa_i  (wb_rd),
    .wd_i  (wb_wdata),
    .ra1_i (rs1),
    .ra2_i (rs2),
    .rd1_o (rs1_data),
    .rd2_o (rs2_data)
  );

  // A source is busy if pending in the scoreboard or produced by the held entry,
  // unless this cycle's write-back delivers it (the regfile forwards that value).
  always_comb begin
    hz1 = need_rs1 && (rs1 != 5'd0)
       && (sb_q[rs1] || (vld_q && need_rd_q && (rd_q == rs1)))
       && !(wb_wen && (wb_rd == rs1));
    hz2 = need_rs2 && (rs2 != 5'd0)
       && (sb_q[rs2] || (vld_q && need_rd_q && (rd_q == rs2)))
       && !(wb_wen && (wb_rd == rs2));
  end

  assign in_ready = !rst && !flush && (!vld_q || out_ready) && !hz1 && !hz2;
  assign accept   = in_valid && in_ready;
  // A flushed entry is killed, so it never counts as issued
  assign issue    = vld_q && out_ready && !flush;

  always_comb begin
    vld_d = vld_q;
    if (accept)                  vld_d = 1'b1;
    else if (out_ready || flush) vld_d = 1'b0;
  end

  // Set after clear so a same-cycle issue and write-back to one register leaves it pending
  always_comb begin
    sb_d = sb_q;
    if (wb_wen)             sb_d[wb_rd] = 1'b0;
    if (issue && need_rd_q) sb_d[rd_q]  = 1'b1;
    sb_d[0] = 1'b0;
  end

  // ---- decode -> output register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= 1'b0;
      sb_q      <= '0;
      pc_q      <= '0;
      opc_q     <= '0;
      alu_q     <= '0;
      br_q      <= '0;
      ls_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      need_rd_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      sb_q  <= sb_d;
      if (accept) begin
        pc_q      <= in_pc;
        opc_q     <= dec.opc;
        alu_q     <= dec.alu;
        br_q      <= dec.br;
        ls_q      <= dec.ls;
        rs1_q     <= rs1_data;
        rs2_q     <= rs2_data;
        imm_q     <= imm_of(dec.imm, in_instr);
        rd_q      <= rd;
        need_rd_q <= need_rd;
        illegal_q <= dec.illegal;
      end
    end
  end

  assign out_valid       = vld_q;
  assign out_pc          = pc_q;
  assign out_opcode_info = opc_q;
  assign out_alu_info    = alu_q;
  assign out_branch_info = br_q;
  assign out_ls_info     = ls_q;
  assign out_rs1_data    = rs1_q;
  assign out_rs2_data    = rs2_q;
  assign out_imm         = imm_q;
  assign out_rd          = rd_q;
  assign out_need_rd     = need_rd_q;
  assign out_illegal     = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an RV64IM instance and an RV32I (EN_M=0)
// instance share the same stimulus.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, wb_wen, flush, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc, wb_wdata;
  logic [4:0]  wb_rd;

  logic        in_ready, out_valid, out_need_rd, out_illegal;
  logic [63:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [11:0] out_opcode_info;
  logic [27:0] out_alu_info;
  logic [5:0]  out_branch_info;
  logic [10:0] out_ls_info;
  logic [4:0]  out_rd;

  logic [31:0] pc32, wd32;
  logic        o32_in_ready, o32_valid, o32_need_rd, o32_illegal;
  logic [31:0] o32_pc, o32_rs1, o32_rs2, o32_imm;
  logic [11:0] o32_opc;
  logic [27:0] o32_alu;
  logic [5:0]  o32_br;
  logic [10:0] o32_ls;
  logic [4:0]  o32_rd;

  assign pc32 = in_pc[31:0];
  assign wd32 = wb_wdata[31:0];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(64), .EN_M(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_wdata(wb_wdata), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode_info(out_opcode_info), .out_alu_info(out_alu_info),
    .out_branch_info(out_branch_info), .out_ls_info(out_ls_info),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rd(out_rd), .out_need_rd(out_need_rd), .out_illegal(out_illegal)
  );

  decode_stage #(.XLEN(32), .EN_M(1'b0)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o32_in_ready), .in_instr(in_instr),
    .in_pc(pc32), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_wdata(wd32), .flush(flush),
    .out_valid(o32_valid), .out_ready(out_ready), .out_pc(o32_pc),
    .out_opcode_info(o32_opc), .out_alu_info(o32_alu),
    .out_branch_info(o32_br), .out_ls_info(o32_ls),
    .out_rs1_data(o32_rs1), .out_rs2_data(o32_rs2), .out_imm(o32_imm),
    .out_rd(o32_rd), .out_need_rd(o32_need_rd), .out_illegal(o32_illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'h00000013; in_pc = '0;
    wb_wen = 1'b0; wb_rd = '0; wb_wdata = '0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_pc", out_pc, 0);
    rst = 1'b0;

    // addi x1,x0,5 then add x2,x1,x1
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 64'h100; #1;
    check("addi_ready", in_ready, 1);
    tick();
    check("addi_valid", out_valid, 1);
    check("addi_imm", out_imm, 64'h5);
    check("addi_opc", out_opcode_info, 12'h010);
    check("addi_alu", out_alu_info, 28'h8000000);
    check("addi_rd", {out_need_rd, out_rd}, 6'h21);
    in_instr = 32'h00108133; in_pc = 64'h104; #1;
    check("raw_stall_held", in_ready, 0);
    tick();
    check("sb1_set", dut.sb_q[1], 1);
    check("raw_stall_c1", in_ready, 0);
    tick();
    check("raw_stall_c2", in_ready, 0);
    tick();
    wb_wen = 1'b1; wb_rd = 5'd1; wb_wdata = 64'd5; #1;
    check("raw_wb_ready", in_ready, 1);
    tick();
    wb_wen = 1'b0;
    check("add_pc", out_pc, 64'h104);
    check("add_rs1", out_rs1_data, 64'd5);
    check("add_rs2", out_rs2_data, 64'd5);
    check("add_opc", out_opcode_info, 12'h004);
    check("sb1_clear", dut.sb_q[1], 0);

    // hold with out_ready low; lui x7,0x12345 waiting
    out_ready = 1'b0; in_instr = 32'h123453B7; in_pc = 64'h108;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("hold_ready", in_ready, 0);
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_pc", out_pc, 64'h104);
      check("hold_rs1", out_rs1_data, 64'd5);
    end
    check("hold_sb2", dut.sb_q[2], 0);
    out_ready = 1'b1; #1;
    check("release_ready", in_ready, 1);
    tick();
    check("lui_pc", out_pc, 64'h108);
    check("lui_imm", out_imm, 64'h12345000);
    check("lui_opc", out_opcode_info, 12'h800);
    check("sb2_set", dut.sb_q[2], 1);

    // flush with the lui entry held and beq presented
    out_ready = 1'b0; flush = 1'b1; in_instr = 32'hFE000EE3; in_pc = 64'h10C; #1;
    check("flush_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_sb7", dut.sb_q[7], 0);
    check("flush_sb2", dut.sb_q[2], 1);
    out_ready = 1'b1; #1;
    check("beq_ready", in_ready, 1);
    tick();
    check("beq_pc", out_pc, 64'h10C);
    check("beq_imm", out_imm, 64'hFFFFFFFFFFFFFFFC);
    check("beq_need_rd", out_need_rd, 0);
    check("beq_br", out_branch_info, 6'h20);
    check("beq_imm32", o32_imm, 32'hFFFFFFFC);

    // jal x0,+2048
    in_instr = 32'h0010006F; in_pc = 64'h110;
    tick();
    check("jal_imm", out_imm, 64'h800);
    check("jal_opc", out_opcode_info, 12'h200);
    check("jal_need_rd", out_need_rd, 0);

    // addi x5,x0,9 issues in the same cycle as a write-back to x5
    in_instr = 32'h00900293; in_pc = 64'h114;
    tick();
    check("x5_rd", {out_need_rd, out_rd}, 6'h25);
    in_valid = 1'b0; wb_wen = 1'b1; wb_rd = 5'd5; wb_wdata = 64'hAA;
    tick();
    wb_wen = 1'b0;
    check("sb5_set_wins", dut.sb_q[5], 1);

    // write-back to x0 must not be visible
    in_valid = 1'b1; in_instr = 32'h00000333; in_pc = 64'h118;
    wb_wen = 1'b1; wb_rd = 5'd0; wb_wdata = 64'hFFFF;
    tick();
    wb_wen = 1'b0;
    check("x0_bypass", out_rs1_data, 0);
    in_pc = 64'h11C;
    tick();
    check("x0_stored_rs1", out_rs1_data, 0);
    check("x0_stored_rs2", out_rs2_data, 0);

    // add x9,x1,x0 reads the stored x1
    in_instr = 32'h000084B3; in_pc = 64'h120;
    tick();
    check("x1_stored", out_rs1_data, 64'd5);

    // addw x3,x1,x1: legal on RV64, illegal on RV32
    in_instr = 32'h001081BB; in_pc = 64'h124;
    tick();
    check("addw64_ill", out_illegal, 0);
    check("addw64_alu", out_alu_info, 28'h0020000);
    check("addw64_opc", out_opcode_info, 12'h002);
    check("addw32_ill", o32_illegal, 1);
    check("addw32_opc", o32_opc, 0);
    check("addw32_alu", o32_alu, 0);
    check("addw32_need_rd", o32_need_rd, 0);

    // mul x3,x1,x1: legal with M, illegal without
    in_instr = 32'h021081B3; in_pc = 64'h128;
    tick();
    check("mul64_alu", out_alu_info, 28'h0001000);
    check("mul32_ill", o32_illegal, 1);
    check("mul32_info", {o32_opc, o32_alu, o32_br, o32_ls}, 0);
    check("mul32_need_rd", o32_need_rd, 0);

    // srai x4,x1,33: shamt[5] set
    in_instr = 32'h4210D213; in_pc = 64'h12C;
    tick();
    check("srai64_alu", out_alu_info, 28'h0100000);
    check("srai64_ill", out_illegal, 0);
    check("srai32_ill", o32_illegal, 1);
    in_valid = 1'b0;
    tick();
    check("sb3_rv64", dut.sb_q[3], 1);
    check("sb3_rv32", dut32.sb_q[3], 0);

    // reset during a stall on x5
    in_valid = 1'b1; in_instr = 32'h00028533; in_pc = 64'h130; #1;
    check("stall_x5", in_ready, 0);
    rst = 1'b1; #1;
    check("rst_ready_low", in_ready, 0);
    tick();
    check("rst2_valid", out_valid, 0);
    check("rst2_sb", dut.sb_q, 0);
    check("rst2_pc", out_pc, 0);
    check("rst2_rs1", out_rs1_data, 0);
    rst = 1'b0; #1;
    check("rst2_ready", in_ready, 1);
    tick();
    check("rst2_accept_pc", out_pc, 64'h130);
    check("rst2_x5_cleared", out_rs1_data, 0);
    in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32/RV64 decode stage: one-entry output register with valid/ready handshakes, internal register file with write-back bypass, and a 32-entry scoreboard that stalls issue on RAW hazards. It sits between the fetch/IF-ID register and execute, and generalises the combinational decoder with XLEN and M-extension selection, illegal-instruction flagging and flow control.

## Interface
Parameters:
- XLEN, 64 — datapath width; legal values are 32 and 64.
- EN_M, 1 — when 1, M-extension instructions decode; when 0 they are illegal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  the fetch side presents an instruction.
- in_ready  out  1  decode accepts the instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- wb_wen / wb_rd / wb_wdata  in  1 / 5 / XLEN  write-back port.
- flush  in  1  kills the held output entry and blocks acceptance for this cycle.
- out_valid  out  1  the decoded entry is valid.
- out_ready  in  1  execute takes the entry.
- out_pc  out  XLEN  registered PC.
- out_opcode_info  out  12  one-hot opcode class (lui … system, MSB first).
- out_alu_info  out  28  ALU op one-hots.
- out_branch_info  out  6  branch op one-hots.
- out_ls_info  out  11  load/store op one-hots.
- out_rs1_data / out_rs2_data  out  XLEN  operands.
- out_imm  out  XLEN  sign-extended immediate.
- out_rd  out  5  destination register.
- out_need_rd  out  1  the instruction writes rd, and rd is not 0.
- out_illegal  out  1  unsupported encoding.

## Operation
- Accept when in_valid & in_ready. The decoded fields, the register data and the PC are captured into the output register.
- Decoding follows the team's RV64IM field layout. For XLEN=32:
  - the regw/immw opcodes, ld, lwu and sd are illegal;
  - W-type bits of alu_info are 0;
  - for slli/srli/srai, instr[25]=1 is illegal.
- EN_M=0: every func7=0000001 reg/regw encoding is illegal.
- Illegal entries: out_illegal=1; opcode/alu/branch/ls info all 0; need_rd=0. The entry is still passed downstream.
- Operand needs:
  - need_rs1 = not (lui, auipc, jal).
  - need_rs2 = alu_reg, alu_regw, branch or store.
- A source is hazardous when all of the following hold:
  - it is needed and its index is not 0;
  - either scoreboard[rs] is set, or the held output entry is valid with need_rd and out_rd==rs;
  - it is not the case that wb_wen & wb_rd==rs this cycle.
- in_ready = ~rst & ~flush & (~out_valid | out_ready) & ~hazard.
- Scoreboard:
  - Set bit out_rd on out_valid & out_ready & out_need_rd.
  - Clear bit wb_rd on wb_wen.
  - If set and clear hit the same index in one cycle, set wins.
  - Bit 0 is never set.
- Register file:
  - x0 reads 0 and writes to it are ignored.
  - Reads are combinational with write-through: when wb_wen and wb_rd equals the read index (not 0), the read returns wb_wdata.
- Flush drops the held entry (out_valid←0 next cycle) and leaves the scoreboard untouched. An entry that is not issued never sets a bit.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N shows out_valid=1 after edge N.
- out_valid update on each edge:
  - set on accept;
  - otherwise cleared on out_ready or flush;
  - otherwise held, with all out_* stable while out_valid & ~out_ready.
- Full throughput (1 instruction per cycle) with no hazards and out_ready held high.
- Back-to-back dependence (rd of entry N used by entry N+1): entry N+1 stalls until the write-back of entry N. It is accepted in the same cycle as that write-back and gets the bypassed data.
- Reset (any cycle, including mid-stall) clears, on the next edge:
  - out_valid and every out_* field;
  - all registers;
  - the scoreboard.
- in_ready is 0 while rst=1.

## Structure
- Shared package decode_pkg holds:
  - opcode constants;
  - the info-vector widths (12/28/6/11) and bit positions;
  - the illegal-decode default.
- Sub-module decode_regfile, parameterised by XLEN: 2 read ports, 1 write port, write-through bypass, x0 hardwired to 0.
- The decode function is pure combinational logic inside decode_stage. The output register and the scoreboard also live in decode_stage.

## Test plan
- After reset, feed addi x1,x0,5 then add x2,x1,x1, with write-back driven 3 cycles after issue → add stalls until the wb cycle and is then accepted. When add issues, out_rs1_data = out_rs2_data = 5 and scoreboard[1] clears.
- out_ready=0 for 4 cycles with an entry held → out_* stable, in_ready=0. Release → the next instruction is accepted the same cycle.
- XLEN=32 with addw, or EN_M=0 with mul x3,x1,x2 → out_illegal=1, info all 0, out_need_rd=0, no scoreboard set.
- flush asserted with the entry held and in_valid=1 → out_valid=0 next cycle, that cycle's instruction is not accepted, scoreboard unchanged.
- Same-cycle issue of rd=x5 and wb to x5 → scoreboard[5]=1 afterwards. A wb to x0 with data 0xFFFF → x0 still reads 0.
- Branch beq with imm=-4 → out_imm=all-ones…FFFC, need_rd=0. jal with imm=+2048 → out_imm=0x800.
